// File: rtl/ym_fm_frame_mixer_if.sv
// Channel-sample input bus and frame-result output bus of the FM frame mixer.
// master drives samples and frame_start, slave is the mixer.
interface ym_fm_frame_mixer_if #(
  parameter int NUM_CH = 6,
  parameter int CH_W   = 3,
  parameter int IN_W   = 9,
  parameter int OUT_W  = 12
);
  logic                     frame_start;
  logic                     ch_valid;
  logic [CH_W-1:0]          ch_index;
  logic [IN_W-1:0]          ch_sample;
  logic [1:0]               pan;
  logic signed [OUT_W-1:0]  out_l;
  logic signed [OUT_W-1:0]  out_r;
  logic                     out_valid;
  logic [NUM_CH-1:0]        ch_seen;
  logic                     sat_l;
  logic                     sat_r;
  logic                     dup_err;

  modport master (
    output frame_start, ch_valid, ch_index, ch_sample, pan,
    input  out_l, out_r, out_valid, ch_seen, sat_l, sat_r, dup_err
  );

  modport slave (
    input  frame_start, ch_valid, ch_index, ch_sample, pan,
    output out_l, out_r, out_valid, ch_seen, sat_l, sat_r, dup_err
  );
endinterface

// File: rtl/ym_fm_frame_mixer.sv
// Per-frame panned stereo mixer of time-multiplexed FM channel samples; YM_MIXER_LADDER_EN adds ladder-DAC crossover.
// Latency: frame_start -> out_valid one cycle; one sample accepted per cycle back-to-back.
// Backpressure: none; duplicate/out-of-range samples are dropped and flagged on sticky dup_err.
module ym_fm_frame_mixer #(
  parameter int NUM_CH = 6,
  parameter int CH_W   = 3,
  parameter int IN_W   = 9,
  parameter int OUT_W  = 12
) (
  input  logic                MCLK,
  input  logic                reset,
  ym_fm_frame_mixer_if.slave  bus
);

  localparam int ACC_W = IN_W + $clog2(NUM_CH) + 1;
  localparam int EXT_W = ACC_W - IN_W - 1;
  localparam int CMP_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

  typedef logic signed [IN_W:0]      smp_t;
  typedef logic signed [ACC_W-1:0]   acc_t;
  typedef logic signed [CMP_W-1:0]   cmp_t;
  typedef logic [NUM_CH-1:0]         mask_t;

  localparam cmp_t MAX_V = (cmp_t'(1) <<< (OUT_W - 1)) - cmp_t'(1);
  localparam cmp_t MIN_V = -(cmp_t'(1) <<< (OUT_W - 1));

  function automatic smp_t contrib(input smp_t s, input logic en);
    smp_t c;
`ifdef YM_MIXER_LADDER_EN
    // Ladder DAC: enabled side is pushed one step away from zero for s>=0, muted side leaks +/-1
    if (en) c = s[IN_W] ? s : s + smp_t'(1);
    else    c = s[IN_W] ? '1 : smp_t'(1);
`else
    c = en ? s : '0;
`endif
    return c;
  endfunction

  function automatic acc_t widen(input smp_t c);
    return {{EXT_W{c[IN_W]}}, c};
  endfunction

  // Returns {saturated, clamped value}
  function automatic logic [OUT_W:0] clamp(input acc_t a);
    cmp_t x;
    x = {{(CMP_W-ACC_W){a[ACC_W-1]}}, a};
    if (x > MAX_V)      return {1'b1, MAX_V[OUT_W-1:0]};
    else if (x < MIN_V) return {1'b1, MIN_V[OUT_W-1:0]};
    else                return {1'b0, x[OUT_W-1:0]};
  endfunction

  logic [0:0]               state_q, state_d;
  acc_t                     acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  mask_t                    seen_q, seen_d;
  logic signed [OUT_W-1:0]  out_l_q, out_l_d, out_r_q, out_r_d;
  logic                     out_valid_q, out_valid_d;
  mask_t                    ch_seen_q, ch_seen_d;
  logic                     sat_l_q, sat_l_d, sat_r_q, sat_r_d;
  logic                     dup_err_q, dup_err_d;

  smp_t   s;
  acc_t   add_l, add_r;
  logic   in_range;
  mask_t  idx_oh;
  logic   is_new;

  always_comb begin
    state_d     = state_q;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    seen_d      = seen_q;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;
    out_valid_d = 1'b0;
    ch_seen_d   = ch_seen_q;
    sat_l_d     = sat_l_q;
    sat_r_d     = sat_r_q;
    dup_err_d   = dup_err_q;

    s        = $signed({1'b0, bus.ch_sample}) - $signed({2'b01, {(IN_W-1){1'b0}}});
    add_l    = widen(contrib(s, bus.pan[1]));
    add_r    = widen(contrib(s, bus.pan[0]));
    in_range = {1'b0, bus.ch_index} < (CH_W+1)'(NUM_CH);
    idx_oh   = mask_t'(1) << bus.ch_index;
    is_new   = (seen_q & idx_oh) == '0;

    if (bus.frame_start) begin
      state_d = ST_ACC;
      if (state_q == ST_ACC) begin
        {sat_l_d, out_l_d} = clamp(acc_l_q);
        {sat_r_d, out_r_d} = clamp(acc_r_q);
        ch_seen_d          = seen_q;
        out_valid_d        = 1'b1;
      end
      // A sample coincident with frame_start opens the new frame
      acc_l_d = '0;
      acc_r_d = '0;
      seen_d  = '0;
      if (bus.ch_valid) begin
        if (in_range) begin
          acc_l_d = add_l;
          acc_r_d = add_r;
          seen_d  = idx_oh;
        end else begin
          dup_err_d = 1'b1;
        end
      end
    end else if (state_q == ST_ACC && bus.ch_valid) begin
      if (in_range && is_new) begin
        acc_l_d = acc_l_q + add_l;
        acc_r_d = acc_r_q + add_r;
        seen_d  = seen_q | idx_oh;
      end else begin
        dup_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      seen_q      <= '0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      out_valid_q <= 1'b0;
      ch_seen_q   <= '0;
      sat_l_q     <= 1'b0;
      sat_r_q     <= 1'b0;
      dup_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      seen_q      <= seen_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
      out_valid_q <= out_valid_d;
      ch_seen_q   <= ch_seen_d;
      sat_l_q     <= sat_l_d;
      sat_r_q     <= sat_r_d;
      dup_err_q   <= dup_err_d;
    end
  end

  assign bus.out_l     = out_l_q;
  assign bus.out_r     = out_r_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ch_seen   = ch_seen_q;
  assign bus.sat_l     = sat_l_q;
  assign bus.sat_r     = sat_r_q;
  assign bus.dup_err   = dup_err_q;

endmodule

// File: tb/tb_ym_fm_frame_mixer.sv
// Bench for ym_fm_frame_mixer: 12-bit and 9-bit output instances share one stimulus stream;
// emitted frames are checked against a queue of expected results.
module tb_ym_fm_frame_mixer;

`ifdef YM_MIXER_LADDER_EN
  localparam bit LAD = 1'b1;
`else
  localparam bit LAD = 1'b0;
`endif

  logic MCLK  = 1'b0;
  logic reset = 1'b1;
  always #5 MCLK = ~MCLK;

  ym_fm_frame_mixer_if #(.NUM_CH(6), .CH_W(3), .IN_W(9), .OUT_W(12)) bus ();
  ym_fm_frame_mixer_if #(.NUM_CH(6), .CH_W(3), .IN_W(9), .OUT_W(9))  bus9 ();

  assign bus9.frame_start = bus.frame_start;
  assign bus9.ch_valid    = bus.ch_valid;
  assign bus9.ch_index    = bus.ch_index;
  assign bus9.ch_sample   = bus.ch_sample;
  assign bus9.pan         = bus.pan;

  ym_fm_frame_mixer #(.NUM_CH(6), .CH_W(3), .IN_W(9), .OUT_W(12)) u_dut (
    .MCLK (MCLK), .reset (reset), .bus (bus)
  );
  ym_fm_frame_mixer #(.NUM_CH(6), .CH_W(3), .IN_W(9), .OUT_W(9)) u_dut9 (
    .MCLK (MCLK), .reset (reset), .bus (bus9)
  );

  typedef struct {
    int        l, r, l9, r9;
    logic [5:0] seen;
    bit        sl9, sr9;
    int        due;
  } exp_t;

  typedef struct {
    logic [5:0]       vld;
    logic [5:0][2:0]  idx;
    logic [5:0][8:0]  smp;
    logic [5:0][1:0]  pan;
    int               l, r, l9, r9;
    logic [5:0]       seen;
    bit               sl9, sr9;
  } vec_t;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc_cnt = 0;
  exp_t exp_q[$];
  vec_t tbl[6];

  always @(posedge MCLK) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc_cnt);
    end
  endtask

  task automatic drive(input bit fs, input bit vld, input logic [2:0] idx,
                       input logic [8:0] smp, input logic [1:0] pn);
    bus.frame_start = fs;
    bus.ch_valid    = vld;
    bus.ch_index    = idx;
    bus.ch_sample   = smp;
    bus.pan         = pn;
    @(posedge MCLK);
    #1;
    bus.frame_start = 1'b0;
    bus.ch_valid    = 1'b0;
  endtask

  task automatic expect_frame(input int l, input int r, input int l9, input int r9,
                              input logic [5:0] seen, input bit sl9, input bit sr9);
    exp_t e;
    e.l = l; e.r = r; e.l9 = l9; e.r9 = r9; e.seen = seen;
    e.sl9 = sl9; e.sr9 = sr9;
    e.due = cyc_cnt + 1;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every out_valid must match the oldest pending frame, exactly one cycle after its frame_start
  always @(negedge MCLK) begin
    if (bus.out_valid) begin : pop
      exp_t e;
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("latency",   cyc_cnt, e.due);
        chk("out_l",     $signed(bus.out_l), e.l);
        chk("out_r",     $signed(bus.out_r), e.r);
        chk("ch_seen",   bus.ch_seen, e.seen);
        chk("sat_l",     bus.sat_l, 0);
        chk("sat_r",     bus.sat_r, 0);
        chk("out_valid9", bus9.out_valid, 1);
        chk("out_l9",    $signed(bus9.out_l), e.l9);
        chk("out_r9",    $signed(bus9.out_r), e.r9);
        chk("sat_l9",    bus9.sat_l, e.sl9);
        chk("sat_r9",    bus9.sat_r, e.sr9);
      end
    end
  end

  initial begin
    bus.frame_start = 1'b0;
    bus.ch_valid    = 1'b0;
    bus.ch_index    = '0;
    bus.ch_sample   = '0;
    bus.pan         = '0;

    tbl[0].vld = 6'h3F; tbl[0].idx = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    tbl[0].smp = {6{9'h140}}; tbl[0].pan = {6{2'b11}};
    tbl[0].l = LAD ? 390 : 384; tbl[0].r = tbl[0].l; tbl[0].l9 = 255; tbl[0].r9 = 255;
    tbl[0].seen = 6'h3F; tbl[0].sl9 = 1; tbl[0].sr9 = 1;

    tbl[1].vld = 6'h3F; tbl[1].idx = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    tbl[1].smp = {9'h100, 9'h100, 9'h100, 9'h100, 9'h100, 9'h1FF};
    tbl[1].pan = {2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    tbl[1].l = LAD ? 6 : 0; tbl[1].r = LAD ? 261 : 255; tbl[1].l9 = tbl[1].l; tbl[1].r9 = 255;
    tbl[1].seen = 6'h3F; tbl[1].sl9 = 0; tbl[1].sr9 = LAD;

    tbl[2].vld = 6'h3F; tbl[2].idx = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    tbl[2].smp = {6{9'h1FF}}; tbl[2].pan = {6{2'b11}};
    tbl[2].l = LAD ? 1536 : 1530; tbl[2].r = tbl[2].l; tbl[2].l9 = 255; tbl[2].r9 = 255;
    tbl[2].seen = 6'h3F; tbl[2].sl9 = 1; tbl[2].sr9 = 1;

    tbl[3].vld = 6'h3F; tbl[3].idx = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    tbl[3].smp = {6{9'h000}}; tbl[3].pan = {6{2'b11}};
    tbl[3].l = -1536; tbl[3].r = -1536; tbl[3].l9 = -256; tbl[3].r9 = -256;
    tbl[3].seen = 6'h3F; tbl[3].sl9 = 1; tbl[3].sr9 = 1;

    // Partial frame with idle gaps and garbage on the invalid slots
    tbl[4].vld = 6'b000011; tbl[4].idx = {3'd2, 3'd2, 3'd2, 3'd2, 3'd4, 3'd1};
    tbl[4].smp = {9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 9'h0C0, 9'h180};
    tbl[4].pan = {2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b10};
    tbl[4].l = 128; tbl[4].r = LAD ? -63 : -64; tbl[4].l9 = tbl[4].l; tbl[4].r9 = tbl[4].r;
    tbl[4].seen = 6'b010010; tbl[4].sl9 = 0; tbl[4].sr9 = 0;

    // Reverse channel order, mixed pans and signs
    tbl[5].vld = 6'h3F; tbl[5].idx = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    tbl[5].smp = {9'h0FF, 9'h101, 9'h080, 9'h180, 9'h000, 9'h1FF};
    tbl[5].pan = {2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
    tbl[5].l = LAD ? 1 : -1; tbl[5].r = 384; tbl[5].l9 = tbl[5].l; tbl[5].r9 = 255;
    tbl[5].seen = 6'h3F; tbl[5].sl9 = 0; tbl[5].sr9 = 1;

    repeat (3) @(posedge MCLK);
    @(negedge MCLK);
    chk("rst_out_l",     bus.out_l, 0);
    chk("rst_out_r",     bus.out_r, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_ch_seen",   bus.ch_seen, 0);
    chk("rst_sat",       {bus.sat_l, bus.sat_r}, 0);
    chk("rst_dup_err",   bus.dup_err, 0);
    chk("rst_out_l9",    bus9.out_l, 0);
    reset = 1'b0;
    @(posedge MCLK);
    #1;

    // Opening frame_start from IDLE must not emit
    drive(1, 0, 3'd0, 9'h000, 2'b00);
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 6; i++)
        drive(0, tbl[k].vld[i], tbl[k].idx[i], tbl[k].smp[i], tbl[k].pan[i]);
      expect_frame(tbl[k].l, tbl[k].r, tbl[k].l9, tbl[k].r9, tbl[k].seen, tbl[k].sl9, tbl[k].sr9);
      drive(1, 0, 3'd0, 9'h000, 2'b00);
    end
    chk("no_dup_err_yet", bus.dup_err, 0);

    // Duplicate ch2 and out-of-range index 7
    drive(0, 1, 3'd2, 9'h180, 2'b11);
    drive(0, 1, 3'd2, 9'h1C0, 2'b11);
    drive(0, 1, 3'd7, 9'h1FF, 2'b11);
    chk("dup_err_set", bus.dup_err, 1);
    expect_frame(LAD ? 129 : 128, LAD ? 129 : 128, LAD ? 129 : 128, LAD ? 129 : 128, 6'b000100, 0, 0);
    drive(1, 0, 3'd0, 9'h000, 2'b00);
    expect_frame(0, 0, 0, 0, 6'h00, 0, 0);
    drive(1, 0, 3'd0, 9'h000, 2'b00);
    repeat (2) drive(0, 0, 3'd0, 9'h000, 2'b00);
    chk("dup_err_sticky", bus.dup_err, 1);

    // Sample coincident with frame_start belongs to the new frame
    drive(0, 1, 3'd0, 9'h110, 2'b11);
    expect_frame(LAD ? 17 : 16, LAD ? 17 : 16, LAD ? 17 : 16, LAD ? 17 : 16, 6'b000001, 0, 0);
    drive(1, 1, 3'd3, 9'h110, 2'b11);
    drive(0, 1, 3'd1, 9'h110, 2'b11);
    expect_frame(LAD ? 34 : 32, LAD ? 34 : 32, LAD ? 34 : 32, LAD ? 34 : 32, 6'b001010, 0, 0);
    drive(1, 0, 3'd0, 9'h000, 2'b00);

    // Reset mid-frame discards partial sums and emits nothing
    for (int i = 0; i < 3; i++) drive(0, 1, 3'(i), 9'h1FF, 2'b11);
    reset = 1'b1;
    repeat (2) @(posedge MCLK);
    #1;
    reset = 1'b0;
    @(negedge MCLK);
    chk("mid_rst_out_l",   bus.out_l, 0);
    chk("mid_rst_ch_seen", bus.ch_seen, 0);
    chk("mid_rst_dup_err", bus.dup_err, 0);
    @(posedge MCLK);
    #1;
    drive(0, 1, 3'd5, 9'h1FF, 2'b11);
    drive(1, 0, 3'd0, 9'h000, 2'b00);
    for (int i = 0; i < 6; i++) drive(0, 1, 3'(i), 9'h120, 2'b11);
    @(negedge MCLK);
    chk("pre_emit_out_l", bus.out_l, 0);
    chk("pre_emit_out_r", bus.out_r, 0);
    @(posedge MCLK);
    #1;
    expect_frame(LAD ? 198 : 192, LAD ? 198 : 192, LAD ? 198 : 192, LAD ? 198 : 192, 6'h3F, 0, 0);
    drive(1, 0, 3'd0, 9'h000, 2'b00);
    repeat (4) drive(0, 0, 3'd0, 9'h000, 2'b00);
    chk("hold_out_l", $signed(bus.out_l), LAD ? 198 : 192);
    chk("hold_dup_err", bus.dup_err, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
